jtag_ir_unit: RTL and testbench



---
 rtl/jtag_ir_unit_if.sv | 27 ++
 rtl/jtag_ir_unit.sv | 130 +++++++++++++
 tb/tb_jtag_ir_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/jtag_ir_unit_if.sv
// jtag_ir_unit_if: TAP-strobe / instruction-register bundle between the TAP
// controller (master) and the EJTAG instruction-register unit (slave).
interface jtag_ir_unit_if #(
    parameter int IR_WIDTH = 5
);
    logic                tlr;
    logic                capture_ir;
    logic                shift_ir;
    logic                update_ir;
    logic                tdi;
    logic                ir_tdo;
    logic [IR_WIDTH-1:0] instr;
    logic [3:0]          sel;
    logic [8:0]          sel_onehot;
    logic                ejtag_boot;
    logic                ir_err;

    modport master (
        output tlr, capture_ir, shift_ir, update_ir, tdi,
        input  ir_tdo, instr, sel, sel_onehot, ejtag_boot, ir_err
    );

    modport slave (
        input  tlr, capture_ir, shift_ir, update_ir, tdi,
        output ir_tdo, instr, sel, sel_onehot, ejtag_boot, ir_err
    );
endinterface

// File: rtl/jtag_ir_unit.sv
// jtag_ir_unit: EJTAG instruction register (capture/shift chain, update
// shadow, registered DR-select decode, EJTAGBOOT/NORMALBOOT flag).
// Optional macro JTAG_IR_SHIFT_CNT_EN: counts shifted bits and rejects
// updates whose shift length differs from IR_WIDTH, raising sticky ir_err.
module jtag_ir_unit #(
    parameter int IR_WIDTH   = 5,
    parameter int IDCODE_VAL = 1
) (
    input  logic           clk,
    input  logic           rst,
    jtag_ir_unit_if.slave  bus
);
    localparam logic [IR_WIDTH-1:0] IDCODE = IR_WIDTH'(IDCODE_VAL);

    // Opcode -> DR select; anything unlisted goes to SEL_ANY (8).
    function automatic logic [3:0] decode(input logic [IR_WIDTH-1:0] v);
        logic [3:0] s;
        s = 4'd8;
        if (&v) begin
            s = 4'd7;
        end else begin
            case (v)
                IR_WIDTH'(0):  s = 4'd6;
                IR_WIDTH'(1):  s = 4'd0;
                IR_WIDTH'(2):  s = 4'd7;
                IR_WIDTH'(3):  s = 4'd1;
                IR_WIDTH'(8):  s = 4'd2;
                IR_WIDTH'(9):  s = 4'd3;
                IR_WIDTH'(10): s = 4'd4;
                IR_WIDTH'(12): s = 4'd5;
                IR_WIDTH'(13): s = 4'd7;
                default:       s = 4'd8;
            endcase
        end
        return s;
    endfunction

    logic [IR_WIDTH-1:0] shift_reg_q, shift_reg_d;
    logic [IR_WIDTH-1:0] instr_q, instr_d;
    logic [3:0]          sel_q, sel_d;
    logic [8:0]          sel_onehot_q, sel_onehot_d;
    logic                ejtag_boot_q, ejtag_boot_d;
    logic                upd_ok;

`ifdef JTAG_IR_SHIFT_CNT_EN
    localparam int CNT_W = $clog2(IR_WIDTH) + 2;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ir_err_q, ir_err_d;

    assign upd_ok = (cnt_q == CNT_W'(IR_WIDTH));

    // Shift-length counter and sticky error; follows the same strobe priority.
    always_comb begin
        cnt_d    = cnt_q;
        ir_err_d = ir_err_q;
        if (bus.tlr) begin
            cnt_d    = '0;
            ir_err_d = 1'b0;
        end else if (bus.capture_ir) begin
            cnt_d = '0;
        end else if (bus.shift_ir) begin
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end else if (bus.update_ir && !upd_ok) begin
            ir_err_d = 1'b1;
        end
    end

    // Counter/error state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            ir_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            ir_err_q <= ir_err_d;
        end
    end

    assign bus.ir_err = ir_err_q;
`else
    assign upd_ok     = 1'b1;
    assign bus.ir_err = 1'b0;
`endif

    // Strobe handling: tlr > capture > shift > update.
    always_comb begin
        shift_reg_d  = shift_reg_q;
        instr_d      = instr_q;
        sel_d        = sel_q;
        ejtag_boot_d = ejtag_boot_q;
        if (bus.tlr) begin
            shift_reg_d = '0;
            instr_d     = IDCODE;
            sel_d       = decode(IDCODE);
        end else if (bus.capture_ir) begin
            shift_reg_d = IR_WIDTH'(2'b01);
        end else if (bus.shift_ir) begin
            shift_reg_d = {bus.tdi, shift_reg_q[IR_WIDTH-1:1]};
        end else if (bus.update_ir && upd_ok) begin
            instr_d = shift_reg_q;
            sel_d   = decode(shift_reg_q);
            if (shift_reg_q == IR_WIDTH'(12))      ejtag_boot_d = 1'b1;
            else if (shift_reg_q == IR_WIDTH'(13)) ejtag_boot_d = 1'b0;
        end
        sel_onehot_d = 9'(1) << sel_d;
    end

    // Instruction-register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg_q  <= '0;
            instr_q      <= IDCODE;
            sel_q        <= 4'd0;
            sel_onehot_q <= 9'd1;
            ejtag_boot_q <= 1'b0;
        end else begin
            shift_reg_q  <= shift_reg_d;
            instr_q      <= instr_d;
            sel_q        <= sel_d;
            sel_onehot_q <= sel_onehot_d;
            ejtag_boot_q <= ejtag_boot_d;
        end
    end

    assign bus.ir_tdo     = shift_reg_q[0];
    assign bus.instr      = instr_q;
    assign bus.sel        = sel_q;
    assign bus.sel_onehot = sel_onehot_q;
    assign bus.ejtag_boot = ejtag_boot_q;
endmodule

// File: tb/tb_jtag_ir_unit.sv
// tb_jtag_ir_unit: directed vectors for jtag_ir_unit (IR_WIDTH=5); expected
// values queued per cycle, checked by a negedge monitor.
module tb_jtag_ir_unit;
`ifdef JTAG_IR_SHIFT_CNT_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    jtag_ir_unit_if #(.IR_WIDTH(5)) bus ();

    jtag_ir_unit #(.IR_WIDTH(5), .IDCODE_VAL(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int          cyc;
        int          fld;
        logic [31:0] val;
        string       nm;
    } exp_t;

    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int fld, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc = cyc;
        e.fld = fld;
        e.val = v;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic expect_state(input int ei, input int es, input bit eb, input bit ee,
                                input string tag);
        push(1, 32'(ei), {tag, ".instr"});
        push(2, 32'(es), {tag, ".sel"});
        push(3, 32'(9'(1) << es), {tag, ".sel_onehot"});
        push(4, 32'(eb), {tag, ".ejtag_boot"});
        push(5, 32'(ee), {tag, ".ir_err"});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // capture, shift n bits of v LSB-first, update; then expect the new state
    task automatic load(input logic [4:0] v, input int n, input int ei, input int es,
                        input bit eb, input bit ee, input string tag);
        bus.capture_ir = 1'b1;
        step();
        bus.capture_ir = 1'b0;
        bus.shift_ir   = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.tdi = v[i];
            push(0, (i == 0) ? 32'd1 : 32'd0, {tag, ".tdo"});
            step();
        end
        bus.shift_ir  = 1'b0;
        bus.update_ir = 1'b1;
        step();
        bus.update_ir = 1'b0;
        expect_state(ei, es, eb, ee, tag);
    endtask

    // Monitor: compare every expectation due this cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] got;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.fld)
                0:       got = 32'(bus.ir_tdo);
                1:       got = 32'(bus.instr);
                2:       got = 32'(bus.sel);
                3:       got = 32'(bus.sel_onehot);
                4:       got = 32'(bus.ejtag_boot);
                default: got = 32'(bus.ir_err);
            endcase
            checks++;
            if (e.cyc != cyc || got !== e.val) begin
                errors++;
                $display("FAIL %s cyc %0d: got %0h expected %0h", e.nm, cyc, got, e.val);
            end
        end
    end

    initial begin
        logic [4:0] tv [6];
        int         ts [6];
        tv = '{5'd0, 5'd2, 5'd3, 5'd8, 5'd10, 5'd1};
        ts = '{6, 7, 1, 2, 4, 0};
        checks = 0;
        errors = 0;
        rst            = 1'b1;
        bus.tlr        = 1'b0;
        bus.capture_ir = 1'b0;
        bus.shift_ir   = 1'b0;
        bus.update_ir  = 1'b0;
        bus.tdi        = 1'b0;

        step();
        step();
        expect_state(1, 0, 0, 0, "reset");
        push(0, 32'd0, "reset.tdo");
        rst = 1'b0;

        load(5'd9,  5, 9,  3, 0, 0, "data");
        load(5'd20, 5, 20, 8, 0, 0, "unknown");
        load(5'd31, 5, 31, 7, 0, 0, "allones");
        for (int k = 0; k < 6; k++)
            load(tv[k], 5, int'(tv[k]), ts[k], 0, 0, "table");

        load(5'd12, 5, 12, 5, 1, 0, "ejtagboot");
        bus.tlr = 1'b1;
        step();
        bus.tlr = 1'b0;
        expect_state(1, 0, 1, 0, "tlr");
        push(0, 32'd0, "tlr.tdo");
        load(5'd13, 5, 13, 7, 0, 0, "normalboot");

        // capture wins over update in the same cycle
        load(5'd9, 5, 9, 3, 0, 0, "prio.pre");
        bus.shift_ir = 1'b1;
        bus.tdi      = 1'b1;
        step();
        step();
        bus.shift_ir   = 1'b0;
        bus.capture_ir = 1'b1;
        bus.update_ir  = 1'b1;
        step();
        bus.capture_ir = 1'b0;
        bus.update_ir  = 1'b1;
        expect_state(9, 3, 0, 0, "prio.cap_upd");
        push(0, 32'd1, "prio.tdo");
        step();
        bus.update_ir = 1'b0;
        // bare update with no shift: accepted normally, rejected with the counter
        if (FEAT) expect_state(9, 3, 0, 1, "prio.upd");
        else      expect_state(1, 0, 0, 0, "prio.upd");

        // reset in the middle of a shift
        load(5'd12, 5, 12, 5, 1, FEAT, "rstmid.pre");
        bus.capture_ir = 1'b1;
        step();
        bus.capture_ir = 1'b0;
        bus.shift_ir   = 1'b1;
        bus.tdi        = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst          = 1'b0;
        bus.shift_ir = 1'b0;
        expect_state(1, 0, 0, 0, "rstmid");
        push(0, 32'd0, "rstmid.tdo");

        // short shift (4 of 5 bits of 10)
        if (FEAT) load(5'd10, 4, 1,  0, 0, 1, "short");
        else      load(5'd10, 4, 20, 8, 0, 0, "short");
        load(5'd10, 5, 10, 4, 0, FEAT, "full10");
        bus.tlr = 1'b1;
        step();
        bus.tlr = 1'b0;
        expect_state(1, 0, 0, 0, "tlr2");

        for (int w = 0; w < 5 && sb.size() > 0; w++) step();
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
